// File: rtl/alt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alt_sched_pkg
// Brief    : Shared types and constants for the alternating-bit scheduler:
//            per-channel context record, its reset value and a channel-index
//            width helper.
// Revision : 1.0 - initial release
// ============================================================================
package alt_sched_pkg;

    // Saved state of one channel's in-progress frame
    typedef struct packed {
        logic first;   // next bit is the first of a frame
        logic prev;    // previous bit of the current frame
        logic ok;      // every bit so far differed from its predecessor
    } ctx_t;

    localparam ctx_t CTX_RESET = '{first: 1'b1, prev: 1'b0, ok: 1'b1};

    // Width of an index able to address n channels (never below 1)
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_N_CH = 4;
    localparam int DEF_CH_W = ch_width(DEF_N_CH);

endpackage
`default_nettype wire

// File: rtl/alt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alt_rr_arbiter
// Brief    : Round-robin search: one-hot grant to the first eligible channel
//            at or after the pointer, wrapping, plus its encoded index.
// Revision : 1.0 - initial release
// ============================================================================
module alt_rr_arbiter
    import alt_sched_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int CH_W = DEF_CH_W
) (
    input  logic [N_CH-1:0] eligible,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_any
);

    int              w_cand;
    logic [CH_W-1:0] w_cand_idx;

    // Walk channels starting at the pointer; the first eligible one wins
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = 0; off < N_CH; off++) begin
            w_cand     = (int'(ptr) + off) % N_CH;
            w_cand_idx = w_cand[CH_W-1:0];
            if (!grant_any && eligible[w_cand_idx]) begin
                grant[w_cand_idx] = 1'b1;
                grant_idx         = w_cand_idx;
                grant_any         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alt_seq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alt_seq_scheduler
// Brief    : Time-shares one alternating-bit checker between N_CH serial
//            streams. Each cycle one channel's bit is granted round-robin,
//            its saved context is stepped, and a pass/fail result is emitted
//            one cycle after each frame's last bit.
//            Optional macro ALT_SCHED_ERRCNT_EN adds a saturating err_cnt
//            output counting failed frames.
// Revision : 1.0 - initial release
// ============================================================================
module alt_seq_scheduler
    import alt_sched_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int ERR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [N_CH-1:0]   req_bit,
    input  logic [N_CH-1:0]   req_last,
    output logic [N_CH-1:0]   req_ready,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_pass,
    input  logic              res_ready,
    output logic              busy
`ifdef ALT_SCHED_ERRCNT_EN
    ,
    output logic [ERR_W-1:0]  err_cnt
`endif
);

    ctx_t            r_ctx [N_CH];
    logic [CH_W-1:0] r_ptr;

    logic [N_CH-1:0] w_eligible;
    logic [N_CH-1:0] w_grant;
    logic [N_CH-1:0] w_active;
    logic [CH_W-1:0] w_idx;
    logic [CH_W-1:0] w_ptr_next;
    logic            w_any;
    logic            w_slot_free;
    logic            w_bit;
    logic            w_last;
    logic            w_close;
    ctx_t            w_cur;
    ctx_t            w_step;

    // A closing bit may only be granted when the result slot can take it
    assign w_slot_free = !res_valid || res_ready;
    assign w_eligible  = req_valid & (~req_last | {N_CH{w_slot_free}});

    alt_rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .grant_any (w_any)
    );

    assign req_ready  = rst_n ? w_grant : '0;
    assign w_bit      = req_bit[w_idx];
    assign w_last     = req_last[w_idx];
    assign w_cur      = r_ctx[w_idx];
    assign w_close    = w_any && w_last;
    assign w_ptr_next = (w_idx == CH_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;

    // Shared step: first bit only records itself, later bits must differ
    always_comb begin
        w_step      = w_cur;
        w_step.prev = w_bit;
        if (w_cur.first) begin
            w_step.first = 1'b0;
        end else begin
            w_step.ok = w_cur.ok & (w_bit ^ w_cur.prev);
        end
    end

    // Write back the granted channel's context; a closed frame starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_ctx[i] <= CTX_RESET;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_grant[i]) begin
                    r_ctx[i] <= w_last ? CTX_RESET : w_step;
                end
            end
        end
    end

    // Round-robin pointer moves past the winner, holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Result slot: a close loads it, a handshake without a close empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_pass  <= 1'b0;
        end else if (w_close) begin
            res_valid <= 1'b1;
            res_ch    <= w_idx;
            res_pass  <= w_step.ok;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_busy
            assign w_active[i] = !r_ctx[i].first;
        end
    endgenerate

    assign busy = |w_active;

`ifdef ALT_SCHED_ERRCNT_EN
    // Count failed frames, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (w_close && !w_step.ok && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alt_seq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alt_seq_scheduler
// Brief    : Self-checking bench for alt_seq_scheduler: frame table, grant
//            rotation, result back-pressure and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alt_seq_scheduler;

    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int ERR_W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] req_valid;
    logic [N_CH-1:0] req_bit;
    logic [N_CH-1:0] req_last;
    logic [N_CH-1:0] req_ready;
    logic            res_valid;
    logic [CH_W-1:0] res_ch;
    logic            res_pass;
    logic            res_ready;
    logic            busy;
`ifdef ALT_SCHED_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt;
`endif

    always #5 clk = ~clk;

    alt_seq_scheduler #(
        .N_CH  (N_CH),
        .CH_W  (CH_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_pass  (res_pass),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef ALT_SCHED_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0] ch;
        logic       pass;
    } res_t;

    typedef struct {
        int         ch;
        int         n;
        logic [7:0] bits;   // bit i is the i-th bit sent
        logic       pass;
    } vec_t;

    res_t       exp_q [$];
    res_t       mon_e;
    vec_t       vecs [8];
    logic [3:0] rot_bits [4];
    logic       rot_pass [4];
    int         errors  = 0;
    int         checks  = 0;
    int         exp_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int ch, input logic pass);
        res_t e;
        e.ch   = ch[1:0];
        e.pass = pass;
        exp_q.push_back(e);
        if (!pass) exp_err++;
    endtask

    task automatic check_err(input string name);
`ifdef ALT_SCHED_ERRCNT_EN
        check(name, err_cnt, exp_err);
`else
        checks = checks + 0;
`endif
    endtask

    // Accepted results are compared against the scoreboard in order
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got ch=%0d pass=%0d expected none", res_ch, res_pass);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_res_ch", res_ch, mon_e.ch);
                check("sb_res_pass", res_pass, mon_e.pass);
            end
        end
    end

    // Send one frame on a single channel and check grants and 1-cycle result latency
    task automatic run_frame(input int ch, input int n, input logic [7:0] bits,
                             input logic exp_pass, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid     = '0;
            req_bit       = '0;
            req_last      = '0;
            req_valid[ch] = 1'b1;
            req_bit[ch]   = bits[i];
            req_last[ch]  = (i == n - 1);
            @(negedge clk);
            check({tag, "_grant"}, req_ready, 4'b0001 << ch);
            if (i == 1) check({tag, "_busy_mid"}, busy, 1);
            if (i == n - 1) push_exp(ch, exp_pass);
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_last  = '0;
        check({tag, "_res_valid"}, res_valid, 1);
        check({tag, "_res_ch"}, res_ch, ch);
        check({tag, "_res_pass"}, res_pass, exp_pass);
        check({tag, "_busy_end"}, busy, 0);
        check_err({tag, "_err_cnt"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pos [4];
        int         mptr;
        int         mptr_n;
        int         cc;
        logic       found;
        logic [3:0] exp_g;

        vecs[0] = '{0, 4, 8'b0000_0101, 1'b1};  // 1,0,1,0
        vecs[1] = '{1, 3, 8'b0000_0011, 1'b0};  // 1,1,0
        vecs[2] = '{2, 1, 8'b0000_0000, 1'b1};  // single 0
        vecs[3] = '{3, 5, 8'b0000_1010, 1'b1};  // 0,1,0,1,0
        vecs[4] = '{0, 6, 8'b0010_0101, 1'b0};  // 1,0,1,0,0,1
        vecs[5] = '{2, 2, 8'b0000_0011, 1'b0};  // 1,1
        vecs[6] = '{1, 8, 8'b1010_1010, 1'b1};  // 0,1,0,1,0,1,0,1
        vecs[7] = '{3, 1, 8'b0000_0001, 1'b1};  // single 1

        rot_bits[0] = 4'b0101; rot_pass[0] = 1'b1;  // 1,0,1,0
        rot_bits[1] = 4'b1010; rot_pass[1] = 1'b1;  // 0,1,0,1
        rot_bits[2] = 4'b0011; rot_pass[2] = 1'b0;  // 1,1,0,0
        rot_bits[3] = 4'b0110; rot_pass[3] = 1'b0;  // 0,1,1,0

        // Reset state, with requests present
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_bit   = '0;
        req_last  = '0;
        res_ready = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_res_pass", res_pass, 0);
        check("rst_busy", busy, 0);
        check_err("rst_err_cnt");
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;

        // All channels valid: grants rotate from 0, frames checked independently
        mptr = 0;
        for (int c = 0; c < 4; c++) pos[c] = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) begin
                req_valid[c] = (pos[c] < 4);
                req_bit[c]   = (pos[c] < 4) ? rot_bits[c][pos[c]] : 1'b0;
                req_last[c]  = (pos[c] == 3);
            end
            @(negedge clk);
            exp_g  = '0;
            found  = 1'b0;
            mptr_n = mptr;
            for (int k = 0; k < 4; k++) begin
                cc = (mptr + k) % 4;
                if (!found && pos[cc] < 4) begin
                    exp_g[cc] = 1'b1;
                    found     = 1'b1;
                    mptr_n    = (cc + 1) % 4;
                end
            end
            check("rot_grant", req_ready, exp_g);
            mptr = mptr_n;
            for (int c = 0; c < 4; c++) begin
                if (req_ready[c] && req_valid[c]) begin
                    if (pos[c] == 3) push_exp(c, rot_pass[c]);
                    pos[c]++;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_last  = '0;
        check("rot_last_valid", res_valid, 1);
        check("rot_last_ch", res_ch, 3);
        check("rot_busy", busy, 0);
        check_err("rot_err_cnt");

        // Table of single-channel frames
        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].ch, vecs[v].n, vecs[v].bits, vecs[v].pass, $sformatf("vec%0d", v));
        end
        @(negedge clk);
        @(posedge clk); #1;

        // Back-pressure: pending result blocks closes but not ordinary bits
        res_ready = 1'b0;
        run_frame(1, 1, 8'b0000_0000, 1'b1, "bp_pend");
        @(posedge clk); #1;
        req_valid = 4'b1100;
        req_last  = 4'b0100;
        req_bit   = 4'b1000;
        @(negedge clk);
        check("bp_last_blocked", req_ready, 4'b1000);
        check("bp_hold_valid", res_valid, 1);
        check("bp_hold_ch", res_ch, 1);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        req_bit   = 4'b0000;
        @(negedge clk);
        check("bp_only_last", req_ready, 4'b0000);
        check("bp_hold_pass", res_pass, 1);
        check("bp_busy", busy, 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release", req_ready, 4'b0100);
        push_exp(2, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
        req_last  = '0;
        check("bp_overwrite_valid", res_valid, 1);
        check("bp_overwrite_ch", res_ch, 2);
        // Channel 3 already holds a 1; another 1 closes it as a failure
        run_frame(3, 1, 8'b0000_0001, 1'b0, "bp_ch3");
        @(negedge clk);
        @(posedge clk); #1;

        // Reset mid-frame with a pending result
        res_ready = 1'b0;
        run_frame(2, 1, 8'b0000_0001, 1'b1, "rm_pend");
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_bit   = 4'b0001;
        req_last  = '0;
        @(posedge clk); #1;
        req_bit   = 4'b0000;
        @(negedge clk);
        check("rm_busy_before", busy, 1);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_err = 0;
        check("rm_busy", busy, 0);
        check("rm_res_valid", res_valid, 0);
        check("rm_res_ch", res_ch, 0);
        check("rm_res_pass", res_pass, 0);
        check("rm_req_ready", req_ready, 0);
        check_err("rm_err_cnt");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rm_ptr_zero", req_ready, 4'b0001);
        req_valid = '0;
        res_ready = 1'b1;
        // Stale context (prev=0, not first) would fail this frame
        run_frame(0, 2, 8'b0000_0010, 1'b1, "rm_fresh");
        @(negedge clk);
        @(posedge clk); #1;

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
